// File: rtl/write_back_queue.sv
// write_back_queue
// In-order write-back buffer in front of the register file's single write
// port. Result writes are accepted through a valid/ready handshake and held
// in a FIFO. The oldest entry drains into the register file when the port is
// not stalled. The block also flags read-after-write hazards for both source
// selects while a matching write is still queued.
//
// Ports
//   clk                 rising-edge clock
//   reset               synchronous, active-high reset
//   in_valid/in_ready   request handshake; in_ready = !full
//   in_dest, in_data    destination index and data of the request
//   wb_stall            holds the head entry; no drain this cycle
//   write_enable        register-file write strobe (= !empty & !wb_stall)
//   Destination_select  register-file write index (head entry, 0 when empty)
//   DATA                register-file write data  (head entry, 0 when empty)
//   Source_select_0/1   register-file read indices checked for hazards
//   hazard_0/1          a queued write targets the matching source select
//   count, empty        occupancy and empty flag
//   drop_15             one-cycle pulse after a discarded dest-15 request
module write_back_queue #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [3:0]                 in_dest,
   input  logic [WIDTH-1:0]           in_data,
   input  logic                       wb_stall,
   output logic                       write_enable,
   output logic [3:0]                 Destination_select,
   output logic [WIDTH-1:0]           DATA,
   input  logic [3:0]                 Source_select_0,
   input  logic [3:0]                 Source_select_1,
   output logic                       hazard_0,
   output logic                       hazard_1,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       empty,
   output logic                       drop_15
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   // R15 holds the externally supplied PC and can never be written.
   localparam logic [3:0] PC_REG = 4'd15;

   logic [3:0]       mem_dest_r [DEPTH];
   logic [WIDTH-1:0] mem_data_r [DEPTH];
   logic [PTR_W-1:0] head_r;
   logic [PTR_W-1:0] tail_r;
   logic [CNT_W-1:0] count_r;
   logic             drop_15_r;

   logic             full_s;
   logic             empty_s;
   logic             accept_s;
   logic             push_s;
   logic             pop_s;
   logic             drop_s;
   logic [DEPTH-1:0] valid_s;
   logic             hazard_0_s;
   logic             hazard_1_s;

   assign full_s   = (count_r == CNT_W'(DEPTH));
   assign empty_s  = (count_r == {CNT_W{1'b0}});
   // Readiness depends only on fullness, so a full queue never passes a
   // request through on the same cycle it pops.
   assign accept_s = in_valid & ~full_s;
   assign push_s   = accept_s & (in_dest != PC_REG);
   assign drop_s   = accept_s & (in_dest == PC_REG);
   assign pop_s    = ~empty_s & ~wb_stall;

   assign in_ready           = ~full_s;
   assign write_enable       = pop_s;
   assign Destination_select = empty_s ? 4'd0 : mem_dest_r[head_r];
   assign DATA               = empty_s ? {WIDTH{1'b0}} : mem_data_r[head_r];
   assign count              = count_r;
   assign empty              = empty_s;
   assign drop_15            = drop_15_r;
   assign hazard_0           = hazard_0_s;
   assign hazard_1           = hazard_1_s;

   // Storage array; contents are left as-is on reset since the pointers
   // alone define which entries are live.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_dest_r[tail_r] <= in_dest;
         mem_data_r[tail_r] <= in_data;
      end
   end

   // Pointers, occupancy and the drop pulse; reset overrides push and pop.
   always_ff @(posedge clk) begin
      if (reset) begin
         head_r    <= {PTR_W{1'b0}};
         tail_r    <= {PTR_W{1'b0}};
         count_r   <= {CNT_W{1'b0}};
         drop_15_r <= 1'b0;
      end else begin
         if (push_s) begin
            tail_r <= tail_r + PTR_W'(1);
         end
         if (pop_s) begin
            head_r <= head_r + PTR_W'(1);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
         drop_15_r <= drop_s;
      end
   end

   // Hazard detection: a slot is live when its distance from the head is
   // below the occupancy; any live slot whose dest matches a select (other
   // than R15) raises that select's hazard.
   always_comb begin
      valid_s    = {DEPTH{1'b0}};
      hazard_0_s = 1'b0;
      hazard_1_s = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         valid_s[i] = ({1'b0, PTR_W'(i) - head_r} < count_r);
         hazard_0_s = hazard_0_s | (valid_s[i] & (mem_dest_r[i] == Source_select_0));
         hazard_1_s = hazard_1_s | (valid_s[i] & (mem_dest_r[i] == Source_select_1));
      end
      hazard_0_s = hazard_0_s & (Source_select_0 != PC_REG);
      hazard_1_s = hazard_1_s & (Source_select_1 != PC_REG);
   end

endmodule

// File: tb/tb_write_back_queue.sv
module tb_write_back_queue;

   localparam int WIDTH = 32;
   localparam int DEPTH = 4;

   logic             clk;
   logic             reset;
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       in_dest;
   logic [WIDTH-1:0] in_data;
   logic             wb_stall;
   logic             write_enable;
   logic [3:0]       Destination_select;
   logic [WIDTH-1:0] DATA;
   logic [3:0]       Source_select_0;
   logic [3:0]       Source_select_1;
   logic             hazard_0;
   logic             hazard_1;
   logic [2:0]       count;
   logic             empty;
   logic             drop_15;

   write_back_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk                (clk),
      .reset              (reset),
      .in_valid           (in_valid),
      .in_ready           (in_ready),
      .in_dest            (in_dest),
      .in_data            (in_data),
      .wb_stall           (wb_stall),
      .write_enable       (write_enable),
      .Destination_select (Destination_select),
      .DATA               (DATA),
      .Source_select_0    (Source_select_0),
      .Source_select_1    (Source_select_1),
      .hazard_0           (hazard_0),
      .hazard_1           (hazard_1),
      .count              (count),
      .empty              (empty),
      .drop_15            (drop_15)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: queue of accepted writes {dest, data}, oldest first.
   logic [35:0] model_q[$];
   logic        model_drop = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic model_hazard(input logic [3:0] sel);
      logic h;
      h = 1'b0;
      if (sel != 4'd15) begin
         foreach (model_q[i]) if (model_q[i][35:32] == sel) h = 1'b1;
      end
      return h;
   endfunction

   // One clock cycle: apply inputs, check all outputs against the model,
   // advance the model, then cross the rising edge.
   task automatic cyc(input logic v, input logic [3:0] d, input logic [31:0] dat,
                      input logic stall, input logic [3:0] s0, input logic [3:0] s1);
      int  sz;
      logic exp_we;
      logic acc;
      in_valid = v; in_dest = d; in_data = dat; wb_stall = stall;
      Source_select_0 = s0; Source_select_1 = s1;
      #3;
      sz     = model_q.size();
      exp_we = (sz > 0) && !stall;
      chk("count",    64'(count),    64'(sz));
      chk("empty",    64'(empty),    64'(sz == 0));
      chk("in_ready", 64'(in_ready), 64'(sz < DEPTH));
      chk("write_enable", 64'(write_enable), 64'(exp_we));
      chk("dest_sel", 64'(Destination_select), (sz > 0) ? 64'(model_q[0][35:32]) : 64'd0);
      chk("data",     64'(DATA),     (sz > 0) ? 64'(model_q[0][31:0]) : 64'd0);
      chk("hazard_0", 64'(hazard_0), 64'(model_hazard(s0)));
      chk("hazard_1", 64'(hazard_1), 64'(model_hazard(s1)));
      chk("drop_15",  64'(drop_15),  64'(model_drop));
      acc = v && (sz < DEPTH);
      if (exp_we) void'(model_q.pop_front());
      if (acc && d != 4'd15) model_q.push_back({d, dat});
      model_drop = acc && (d == 4'd15);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic v, input logic stall);
      reset = 1'b1; in_valid = v; in_dest = 4'd7; in_data = 32'h0BAD_0BAD;
      wb_stall = stall;
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_q.delete();
      model_drop = 1'b0;
   endtask

   initial begin
      reset = 1'b0; in_valid = 1'b0; in_dest = 4'd0; in_data = 32'd0;
      wb_stall = 1'b0; Source_select_0 = 4'd0; Source_select_1 = 4'd0;
      #1;
      do_reset(1'b0, 1'b0);

      // Reset state, then single push with one-cycle latency.
      cyc(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd0);
      cyc(1'b1, 4'd3, 32'hA5A5_A5A5, 1'b0, 4'd3, 4'd0);
      cyc(1'b0, 4'd0, 32'd0, 1'b0, 4'd3, 4'd3);
      cyc(1'b0, 4'd0, 32'd0, 1'b0, 4'd3, 4'd0);

      // Fill under stall, refused 5th request, then ordered drain.
      for (int i = 1; i <= 4; i++) cyc(1'b1, 4'(i), 32'h1000 + 32'(i), 1'b1, 4'd2, 4'd4);
      cyc(1'b1, 4'd9, 32'hDEAD, 1'b1, 4'd9, 4'd1);
      for (int i = 0; i < 5; i++) cyc(1'b0, 4'd0, 32'd0, 1'b0, 4'd4, 4'd1);

      // Full queue drained with in_valid held high: no pass-through.
      for (int i = 1; i <= 4; i++) cyc(1'b1, 4'(i + 4), 32'h2000 + 32'(i), 1'b1, 4'd0, 4'd0);
      for (int i = 0; i < 6; i++) cyc(1'b1, 4'(10 + i % 4), 32'h3000 + 32'(i), 1'b0, 4'd10, 4'd8);
      for (int i = 0; i < 5; i++) cyc(1'b0, 4'd0, 32'd0, 1'b0, 4'd10, 4'd13);

      // Hazard checks on dest 5.
      cyc(1'b1, 4'd5, 32'h55, 1'b1, 4'd5, 4'd6);
      cyc(1'b0, 4'd0, 32'd0, 1'b1, 4'd5, 4'd6);
      cyc(1'b0, 4'd0, 32'd0, 1'b1, 4'd15, 4'd6);
      cyc(1'b0, 4'd0, 32'd0, 1'b0, 4'd5, 4'd6);
      cyc(1'b0, 4'd0, 32'd0, 1'b0, 4'd5, 4'd6);

      // Dest-15 request is discarded and pulses drop_15 for one cycle.
      cyc(1'b1, 4'd15, 32'h1234, 1'b0, 4'd15, 4'd15);
      cyc(1'b0, 4'd0, 32'd0, 1'b0, 4'd15, 4'd0);
      cyc(1'b0, 4'd0, 32'd0, 1'b0, 4'd15, 4'd0);

      // Reset with three entries queued and in_valid high.
      for (int i = 0; i < 3; i++) cyc(1'b1, 4'(i + 1), 32'h4000 + 32'(i), 1'b1, 4'd1, 4'd2);
      do_reset(1'b1, 1'b1);
      cyc(1'b0, 4'd0, 32'd0, 1'b0, 4'd1, 4'd2);

      // Randomized traffic against the reference model.
      for (int i = 0; i < 400; i++) begin
         cyc(($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0,
             4'($urandom_range(0, 15)),
             32'($urandom),
             ($urandom_range(0, 99) < 35) ? 1'b1 : 1'b0,
             4'($urandom_range(0, 15)),
             4'($urandom_range(0, 15)));
      end
      cyc(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 4'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/write_back_queue.md
# write_back_queue

Buffered write-back stage sitting directly upstream of the register file's single write port (write_enable / Destination_select / DATA). It accepts result writes through a valid/ready handshake, holds them in an in-order FIFO and drains at most one per cycle into the register file unless stalled. It also reports read-after-write hazards for both register-file source selects, so the datapath can stall operand reads while a newer value is still queued.

## Interface

- WIDTH, 32, data width; must match the register file.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  producer has a write request.
- in_ready  out  1  queue can accept; equals !full.
- in_dest  in  4  destination register index for the request.
- in_data  in  WIDTH  write data for the request.
- wb_stall  in  1  inhibits draining this cycle; the write port is busy.
- write_enable  out  1  register-file write strobe.
- Destination_select  out  4  register-file write index.
- DATA  out  WIDTH  register-file write data.
- Source_select_0  in  4  register-file read index 0, for the hazard check.
- Source_select_1  in  4  register-file read index 1, for the hazard check.
- hazard_0  out  1  a queued write targets Source_select_0.
- hazard_1  out  1  a queued write targets Source_select_1.
- count  out  log2(DEPTH)+1  current occupancy.
- empty  out  1  count == 0.
- drop_15  out  1  registered one-cycle pulse: a dest-15 request was discarded.

## Operation

- Push occurs when in_valid & in_ready and in_dest != 15. The entry {in_dest, in_data} is written at the tail, and the tail pointer increments modulo DEPTH.
- A request with dest 15 is handshaken normally (in_valid & in_ready) but not stored. R15 is the externally supplied PC and is not writable. drop_15 is high in the following cycle.
- Pop occurs when write_enable is high. The head pointer increments modulo DEPTH.
- Write port outputs:
  - write_enable = !empty & !wb_stall.
  - Destination_select and DATA equal the head entry when !empty, else 0.
- Occupancy: count += push − pop. A simultaneous push and pop leaves count unchanged. Push when full is impossible because in_ready is low. Pop when empty is impossible.
- No pass-through when full: in_ready depends only on full, never on a same-cycle pop.
- Hazards:
  - hazard_k = 1 iff some valid entry, including the head, has dest == Source_select_k, with k in {0,1}.
  - Source_select_k == 15 never produces a hazard.
  - Hazards are combinational from the FIFO state and Source_select; in_dest is not included.
- Ordering: writes reach the register file strictly in accept order. Two queued writes to the same register are both performed, and the last one wins.
- Pointer wrap: each pointer carries an extra wrap bit, or count is used, to distinguish full from empty.

## Timing

- Reset (synchronous): head = tail = 0, count = 0, empty = 1, in_ready = 1, write_enable = 0, Destination_select = 0, DATA = 0, hazard_0 = hazard_1 = 0, drop_15 = 0. FIFO contents need not be cleared. Reset overrides any push or pop in the same cycle.
- Latency: a request accepted at edge N sets write_enable in cycle N+1 if the queue was empty and wb_stall is low. The register file then captures it at edge N+1.
- Throughput: one accept and one drain per cycle sustained.
- Hazard for the accepted register rises in cycle N+1. It falls in the cycle after the last matching entry pops.
- wb_stall high holds the head. Outputs other than write_enable remain stable.
- drop_15 asserts in cycle N+1 for a dest-15 request accepted at edge N, and holds for one cycle per drop.

## Test plan

- Reset, then push {dest 3, 0xA5A5A5A5}: in cycle N+1, write_enable = 1, Destination_select = 3, DATA = 0xA5A5A5A5. empty returns to 1 after edge N+1.
- Hold wb_stall = 1 and push 4 entries (dest 1..4): count = 4, in_ready = 0, and a 5th in_valid is not accepted. Release wb_stall: writes for dests 1, 2, 3, 4 appear on consecutive cycles.
- Full queue with wb_stall = 0 and in_valid held high: in_ready stays 0 in the cycle the pop occurs and rises the next cycle. count never exceeds 4.
- Queue dest 5 under stall with Source_select_0 = 5 and Source_select_1 = 6: hazard_0 = 1, hazard_1 = 0. With Source_select_0 = 15: hazard_0 = 0. After the dest-5 entry drains, hazard_0 = 0.
- Push dest 15 with data 0x1234: no write_enable, count unchanged, drop_15 pulses for one cycle.
- Assert reset with 3 entries queued and in_valid high: next cycle count = 0, write_enable = 0, in_ready = 1, no register-file write.
